// File: rtl/da_rom_loader.sv
// Distributed-arithmetic ROM loader: collects NTAPS signed coefficients, then streams
// all 2^NTAPS partial sums with their addresses into the DA controller's ROM write port.
module da_rom_loader #(
   parameter int NTAPS = 4,
   parameter int CW    = 8,
   parameter int DW    = CW + 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [CW-1:0]        coef_in,
   input  logic                 coef_valid,
   output logic                 coef_ready,
   output logic [NTAPS-1:0]     rom_addr,
   output logic [DW-1:0]        rom_data,
   output logic                 rom_valid,
   input  logic                 rom_ready,
   output logic                 cload,
   output logic                 done
);

   localparam int CNT_W = $clog2(NTAPS) + 1;

   typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_EMIT, S_DONE} state_t;

   state_t                    state_q, state_d;
   logic [NTAPS-1:0][CW-1:0]  coef_q, coef_d;
   logic [CNT_W-1:0]          count_q, count_d;
   logic                      coef_ready_q, coef_ready_d;
   logic                      rom_valid_q, rom_valid_d;
   logic                      cload_q, cload_d;
   logic                      done_q, done_d;
   logic [NTAPS-1:0]          rom_addr_q, rom_addr_d;
   logic signed [DW-1:0]      rom_data_q, rom_data_d;

   logic                      coef_hs;
   logic                      rom_hs;
   logic [NTAPS-1:0]          addr_nxt;

   // Sum of every coefficient whose tap bit is set in addr, each sign-extended to DW.
   function automatic logic signed [DW-1:0] partial_sum(
      input logic [NTAPS-1:0]          addr,
      input logic [NTAPS-1:0][CW-1:0]  c
   );
      logic signed [DW-1:0] acc;
      acc = '0;
      for (int i = 0; i < NTAPS; i++) begin
         if (addr[i]) acc = acc + $signed({{(DW-CW){c[i][CW-1]}}, c[i]});
      end
      return acc;
   endfunction

   assign coef_hs  = coef_valid & coef_ready_q;
   assign rom_hs   = rom_valid_q & rom_ready;
   assign addr_nxt = rom_addr_q + NTAPS'(1);

   always_comb begin
      state_d      = state_q;
      coef_d       = coef_q;
      count_d      = count_q;
      coef_ready_d = coef_ready_q;
      rom_valid_d  = rom_valid_q;
      cload_d      = cload_q;
      done_d       = done_q;
      rom_addr_d   = rom_addr_q;
      rom_data_d   = rom_data_q;
      case (state_q)
         S_IDLE: begin
            coef_ready_d = 1'b1;
            rom_addr_d   = '0;
            rom_data_d   = '0;
            if (coef_hs) begin
               coef_d[0] = coef_in;
               count_d   = CNT_W'(1);
               if (NTAPS == 1) begin
                  state_d      = S_EMIT;
                  coef_ready_d = 1'b0;
                  rom_valid_d  = 1'b1;
                  cload_d      = 1'b1;
               end else begin
                  state_d = S_COLLECT;
               end
            end
         end
         S_COLLECT: begin
            if (coef_hs) begin
               for (int i = 0; i < NTAPS; i++) begin
                  if (count_q == CNT_W'(i)) coef_d[i] = coef_in;
               end
               count_d = count_q + CNT_W'(1);
               if (count_q == CNT_W'(NTAPS - 1)) begin
                  state_d      = S_EMIT;
                  coef_ready_d = 1'b0;
                  rom_valid_d  = 1'b1;
                  cload_d      = 1'b1;
                  rom_addr_d   = '0;
                  rom_data_d   = '0;
               end
            end
         end
         S_EMIT: begin
            if (rom_hs) begin
               // Last address: hold it and close the load window instead of wrapping.
               if (&rom_addr_q) begin
                  state_d     = S_DONE;
                  rom_valid_d = 1'b0;
                  cload_d     = 1'b0;
                  done_d      = 1'b1;
               end else begin
                  rom_addr_d = addr_nxt;
                  rom_data_d = partial_sum(addr_nxt, coef_q);
               end
            end
         end
         S_DONE: begin
            state_d      = S_IDLE;
            done_d       = 1'b0;
            coef_ready_d = 1'b1;
            count_d      = '0;
            rom_addr_d   = '0;
            rom_data_d   = '0;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         coef_q       <= '0;
         count_q      <= '0;
         coef_ready_q <= 1'b0;
         rom_valid_q  <= 1'b0;
         cload_q      <= 1'b0;
         done_q       <= 1'b0;
         rom_addr_q   <= '0;
         rom_data_q   <= '0;
      end else begin
         state_q      <= state_d;
         coef_q       <= coef_d;
         count_q      <= count_d;
         coef_ready_q <= coef_ready_d;
         rom_valid_q  <= rom_valid_d;
         cload_q      <= cload_d;
         done_q       <= done_d;
         rom_addr_q   <= rom_addr_d;
         rom_data_q   <= rom_data_d;
      end
   end

   assign coef_ready = coef_ready_q;
   assign rom_valid  = rom_valid_q;
   assign cload      = cload_q;
   assign done       = done_q;
   assign rom_addr   = rom_addr_q;
   assign rom_data   = rom_data_q;

endmodule

// File: tb/tb_da_rom_loader.sv
// Directed bench for da_rom_loader: loads coefficient sets and checks the emitted DA table.
module tb_da_rom_loader;

   localparam int NTAPS = 4;
   localparam int CW    = 8;
   localparam int DW    = CW + 2;

   logic             clk = 1'b0;
   logic             reset;
   logic [CW-1:0]    coef_in;
   logic             coef_valid;
   logic             coef_ready;
   logic [NTAPS-1:0] rom_addr;
   logic [DW-1:0]    rom_data;
   logic             rom_valid;
   logic             rom_ready;
   logic             cload;
   logic             done;

   int n_checks = 0;
   int n_err    = 0;
   int got[16];
   int mc[4];

   da_rom_loader #(.NTAPS(NTAPS), .CW(CW), .DW(DW)) dut (
      .clk(clk), .reset(reset), .coef_in(coef_in), .coef_valid(coef_valid),
      .coef_ready(coef_ready), .rom_addr(rom_addr), .rom_data(rom_data),
      .rom_valid(rom_valid), .rom_ready(rom_ready), .cload(cload), .done(done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int rdata();
      return int'($signed(rom_data));
   endfunction

   task automatic load(input int a, input int b, input int c, input int d,
                       input int ga, input int gb, input int gc, input int gd);
      int cv[4];
      int gv[4];
      bit hs;
      bit ok;
      cv = '{a, b, c, d};
      gv = '{ga, gb, gc, gd};
      mc = cv;
      for (int k = 0; k < 4; k++) begin
         coef_valid = 1'b0;
         repeat (gv[k]) tick();
         coef_valid = 1'b1;
         coef_in    = cv[k][CW-1:0];
         ok = 1'b0;
         for (int t = 0; t < 20; t++) begin
            hs = coef_ready;
            tick();
            if (hs) begin
               ok = 1'b1;
               break;
            end
         end
         if (!ok) check("coef_hs_timeout", 0, 1);
      end
      coef_valid = 1'b0;
   endtask

   // mode 0: rom_ready always high; mode 1: low one cycle then high two.
   task automatic run_emit(input int mode, input int stop_at, input bit poke);
      int n;
      int cl;
      int exp;
      bit rdy;
      bit stalled;
      int pa;
      int pd;
      n = 0;
      cl = 0;
      stalled = 1'b0;
      pa = 0;
      pd = 0;
      check("first_valid", rom_valid, 1);
      check("first_addr", rom_addr, 0);
      for (int c = 0; c < 200; c++) begin
         if (stop_at >= 0 && rom_valid && int'(rom_addr) == stop_at) return;
         if (!rom_valid) break;
         if (cload) cl++;
         check("emit_coef_ready", coef_ready, 0);
         if (stalled) begin
            check("stall_addr", rom_addr, pa);
            check("stall_data", rdata(), pd);
         end
         rdy = (mode == 0) ? 1'b1 : ((c % 3) != 0);
         rom_ready  = rdy;
         coef_valid = poke;
         coef_in    = 8'd99;
         if (rdy && n < 16) begin
            check("addr_order", rom_addr, n);
            got[n] = rdata();
            exp = 0;
            for (int i = 0; i < 4; i++) if (n[i]) exp += mc[i];
            check("table_entry", got[n], exp);
            n++;
         end
         stalled = !rdy;
         pa = rom_addr;
         pd = rdata();
         tick();
      end
      rom_ready  = 1'b0;
      coef_valid = 1'b0;
      check("n_entries", n, 16);
      if (mode == 0) check("cload_cycles", cl, 16);
      check("done_pulse", done, 1);
      check("valid_off", rom_valid, 0);
      check("cload_off", cload, 0);
      check("addr_hold_done", rom_addr, 15);
      tick();
      check("done_one_cycle", done, 0);
      check("coef_ready_back", coef_ready, 1);
      check("addr_idle", rom_addr, 0);
   endtask

   initial begin
      reset      = 1'b1;
      coef_in    = '0;
      coef_valid = 1'b0;
      rom_ready  = 1'b0;
      tick();
      check("rst_coef_ready", coef_ready, 0);
      check("rst_rom_valid", rom_valid, 0);
      check("rst_cload", cload, 0);
      check("rst_done", done, 0);
      check("rst_addr", rom_addr, 0);
      check("rst_data", rdata(), 0);
      reset = 1'b0;
      tick();
      check("idle_coef_ready", coef_ready, 1);

      // Powers of two: each entry equals its address.
      load(1, 2, 4, 8, 0, 0, 0, 0);
      run_emit(0, -1, 1'b0);
      for (int a = 0; a < 16; a++) check("pow2_identity", got[a], a);

      // Most negative coefficients.
      load(-128, -128, -128, -128, 0, 0, 0, 0);
      run_emit(0, -1, 1'b0);
      check("neg_a0", got[0], 0);
      check("neg_a1", got[1], -128);
      check("neg_a3", got[3], -256);
      check("neg_a15", got[15], -512);

      // Most positive coefficients.
      load(127, 127, 127, 127, 0, 0, 0, 0);
      run_emit(0, -1, 1'b0);
      check("pos_a15", got[15], 508);

      // Mixed signs under rom_ready back-pressure.
      load(3, -5, 7, -1, 0, 0, 0, 0);
      run_emit(1, -1, 1'b0);
      check("mix_a5", got[5], 10);
      check("mix_a10", got[10], -6);
      check("mix_a15", got[15], 4);

      // Gapped coefficient delivery, then coef_valid=99 pushed during EMIT.
      load(10, 20, 30, 40, 3, 0, 2, 1);
      run_emit(0, -1, 1'b1);
      check("gap_a1", got[1], 10);
      check("gap_a8", got[8], 40);
      check("gap_a15", got[15], 100);

      // Reset mid-emit at address 6.
      load(1, 2, 4, 8, 0, 0, 0, 0);
      run_emit(0, 6, 1'b0);
      check("abort_at_addr6", rom_addr, 6);
      rom_ready = 1'b0;
      reset     = 1'b1;
      tick();
      reset = 1'b0;
      check("abort_coef_ready", coef_ready, 0);
      check("abort_rom_valid", rom_valid, 0);
      check("abort_cload", cload, 0);
      check("abort_done", done, 0);
      check("abort_addr", rom_addr, 0);
      check("abort_data", rdata(), 0);
      tick();
      check("abort_idle_ready", coef_ready, 1);
      load(1, 1, 1, 1, 0, 0, 0, 0);
      run_emit(0, -1, 1'b0);
      check("reload_a6", got[6], 2);
      check("reload_a15", got[15], 4);

      // Reset together with coef_valid stores nothing.
      coef_valid = 1'b1;
      coef_in    = 8'd55;
      reset      = 1'b1;
      tick();
      reset = 1'b0;
      check("rstv_coef_ready0", coef_ready, 0);
      check("rstv_no_valid", rom_valid, 0);
      coef_valid = 1'b0;
      tick();
      check("rstv_coef_ready1", coef_ready, 1);
      load(2, 4, 8, 16, 0, 0, 0, 0);
      run_emit(0, -1, 1'b0);
      check("rstv_a1", got[1], 2);
      check("rstv_a15", got[15], 30);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/da_rom_loader.md
Name: da_rom_loader

Overview:
- Write-side feeder for the distributed-arithmetic FIR ROM.
- Accepts NTAPS raw signed coefficients over a valid/ready stream.
- Computes all 2^NTAPS DA partial sums. Entry a = sum of coef[i] over every bit i set in a.
- Streams the entries, with address, into the ROM write port of the DA controller. The cload/rom_valid pair is what the controller consumes as CLOAD/valid_in while it is idle.

Parameters:
- NTAPS, 4, number of filter taps; ROM depth is 2^NTAPS.
- CW, 8, coefficient width, signed two's complement.
- DW, CW+2, ROM entry width; must be at least CW+clog2(NTAPS) so no partial sum overflows.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- coef_in  in  CW  signed coefficient.
- coef_valid  in  1  coef_in is valid.
- coef_ready  out  1  loader accepts a coefficient this cycle.
- rom_addr  out  NTAPS  ROM write address.
- rom_data  out  DW  partial sum for rom_addr, sign-extended.
- rom_valid  out  1  rom_addr/rom_data are valid.
- rom_ready  in  1  sink takes the entry this cycle.
- cload  out  1  coefficient-load window is active.
- done  out  1  one-cycle pulse after the last entry is taken.

Behaviour:
- All outputs are registered.
- Reset values: coef_ready=0, rom_valid=0, cload=0, done=0, rom_addr=0, rom_data=0, coefficient count=0. The FSM resets to IDLE.
- Reset wins over every other input in the same cycle. Reset during any state aborts the operation, discards stored coefficients and returns the FSM to IDLE, with the reset output values holding the cycle after.
- FSM states:
  - IDLE: coef_ready=1 starting the cycle after reset deasserts. A coefficient handshake (coef_valid & coef_ready) stores coef[0] and moves to COLLECT. If NTAPS=1, it moves directly to EMIT.
  - COLLECT: coef_ready=1. Each handshake stores coef[k] at k = count and increments count. Gaps in coef_valid are allowed, with no timeout. On the handshake storing coef[NTAPS-1], coef_ready drops to 0 on the next edge and the FSM enters EMIT.
  - EMIT: coef_ready=0 and cload=1. On the first EMIT cycle, rom_valid=1, rom_addr=0, rom_data=0. On each rom_valid & rom_ready cycle, rom_addr increments and rom_data updates to the sum for the new address on the same edge. The sum is combinational over the stored coefficients, sign-extended to DW. With rom_ready held high, throughput is one entry per cycle. If rom_ready is low, addr, data and valid hold unchanged with no gaps. On the handshake at address 2^NTAPS-1, the next edge sets rom_valid=0, cload=0, done=1, and the FSM enters DONE.
  - DONE: done=1 for exactly one cycle, then IDLE with coef_ready=1. Stored coefficients are retained until the next load overwrites them.
- Latency:
  - Last coefficient handshake at edge T gives rom_valid=1 at addr 0 after edge T.
  - Minimum load length is NTAPS + 2^NTAPS + 1 cycles, from the first coefficient handshake through the done pulse.
- coef_valid is ignored outside IDLE/COLLECT. rom_ready is ignored when rom_valid=0.
- rom_addr does not wrap within a load. The final increment is suppressed, so rom_addr holds 2^NTAPS-1 in DONE and returns to 0 on entry to IDLE.
- Arithmetic: signed addition at DW bits. No saturation is needed because DW covers the full range. With the defaults, the range is -512..508.

Test Plan:
- Coefficients 1, 2, 4, 8 back-to-back with rom_ready=1 -> rom_data equals rom_addr for 0..15; cload high for 16 cycles; done pulses on the cycle after addr 15; coef_ready returns to 1 one cycle later.
- Coefficients -128 ×4 -> addr 0 gives 0; addr 1 gives -128 (0x380); addr 3 gives -256; addr 15 gives -512 (0x200). Coefficients 127 ×4 -> addr 15 gives 508 (0x1FC).
- Coefficients 3, -5, 7, -1 with rom_ready toggling in a 1-low/2-high pattern -> 16 unique handshakes in address order; addr/data stable while rom_ready=0; addr 5 gives 10, addr 10 gives -6, addr 15 gives 4.
- coef_valid with idle gaps of 0–3 cycles during COLLECT -> exactly 4 coefficients stored. coef_valid=1 with value 99 during EMIT -> coef_ready=0 and the value is ignored, so table entries are unchanged.
- reset asserted at EMIT addr 6 -> next cycle all outputs take reset values. A new load of 1, 1, 1, 1 afterwards -> addr 15 gives 4 and no stale data appears.
- reset and coef_valid asserted together -> nothing is stored; coef_ready=0 in the cycle after reset and 1 in the cycle after that.
